// File: rtl/pdua_int_pkg.sv
// Shared types and helpers for the PDUA interrupt controller.
// Holds the FSM state enum, the default vector base and the vector helper.
package pdua_int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } int_state_t;

  localparam logic [7:0] VEC_BASE_DEF = 8'hF0;

  // Vector for line idx, two bytes apart; caller truncates to its width.
  function automatic logic [15:0] vector_of(
    input logic [15:0] base,
    input logic [2:0]  idx
  );
    return base + {12'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/pdua_int_ctrl_sync.sv
// One request line: 2-flop synchroniser, previous-value flop, rise pulse.
// Ports: clk, rst (async active-low), irq (async in), rise (1-cycle pulse).
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/pdua_int_ctrl.sv
// PDUA interrupt controller: pending latch, enable mask, priority pick, FSM.
// Ports: clk, rst, irq_in, ien_wr/ien_data, int_clr, eoi -> int_req, int_vector, pending, in_service.
module pdua_int_ctrl
  import pdua_int_pkg::*;
#(
  parameter int                    N_IRQ      = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] VEC_BASE   = DATA_WIDTH'(VEC_BASE_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IRQ-1:0]      irq_in,
  input  logic                  ien_wr,
  input  logic [DATA_WIDTH-1:0] ien_data,
  input  logic                  int_clr,
  input  logic                  eoi,
  output logic                  int_req,
  output logic [DATA_WIDTH-1:0] int_vector,
  output logic [N_IRQ-1:0]      pending,
  output logic                  in_service
);

  int_state_t       state;
  int_state_t       state_n;
  logic [2:0]       cur;
  logic [2:0]       cur_n;
  logic [2:0]       win;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] ien;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] clr_mask;
  logic [N_IRQ-1:0] pending_n;
  logic             do_clr;
  logic             unused_ien;

  // Only the low N_IRQ bits of the bus carry mask bits.
  assign unused_ien = ^ien_data;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .irq  (irq_in[i]),
      .rise (rise[i])
    );
  end

  assign elig = pending & ien;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) win = 3'(i);
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    do_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|elig) begin
          state_n = REQ;
          cur_n   = win;
        end
      end
      REQ: begin
        if (int_clr) begin
          state_n = SVC;
          do_clr  = 1'b1;
        end
      end
      SVC: begin
        if (eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr_mask[i] = do_clr && (cur == 3'(i));
    end
  end

  // A fresh rise beats a same-cycle acknowledge.
  assign pending_n = (pending & ~clr_mask) | rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cur     <= 3'd0;
      pending <= '0;
      ien     <= '0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      pending <= pending_n;
      if (ien_wr) ien <= ien_data[N_IRQ-1:0];
    end
  end

  assign int_req    = (state == REQ);
  assign in_service = (state == SVC);
  assign int_vector = (state == IDLE) ? '0 :
                      DATA_WIDTH'(vector_of(16'(VEC_BASE), cur));

endmodule

// File: doc/pdua_int_ctrl.md
# pdua_int_ctrl

Interrupt controller that sits directly upstream of the PDUA core's 1-bit `INT` capture register. It collects up to `N_IRQ` asynchronous external request lines, synchronises and edge-detects them, holds them as pending, applies a software-written enable mask, and picks the highest-priority enabled request. It then presents a single level request plus an 8-bit service vector to the core. The microcode `int_clr` strobe acknowledges the request, and a separate end-of-interrupt strobe closes the service window.

## Interface
- `N_IRQ`, 4: number of external request lines (1..8).
- `DATA_WIDTH`, 8: core data width; width of vector and enable-write data.
- `VEC_BASE`, 8'hF0: vector for line 0; line i vector = `VEC_BASE + 2*i`, modulo 2^DATA_WIDTH.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst`=0 resets immediately).
- `irq_in`  in  N_IRQ  external requests, asynchronous, rising-edge significant.
- `ien_wr`  in  1  one-cycle strobe; load enable mask from `ien_data`.
- `ien_data`  in  DATA_WIDTH  mask source (core busC); bits [N_IRQ-1:0] used, rest ignored.
- `int_clr`  in  1  acknowledge from microcode (r_data bit 4).
- `eoi`  in  1  end-of-interrupt strobe from core.
- `int_req`  out  1  level request to core INT register.
- `int_vector`  out  DATA_WIDTH  vector of the request being raised or serviced.
- `pending`  out  N_IRQ  latched pending bits (status).
- `in_service`  out  1  high while a request is being serviced.

## Operation
- Per line: 2-flop synchroniser, then a previous-value flop; rise = `sync2 & ~prev`.
- A rise sets `pending[i]`. Pending does not count: repeated rises while set leave a single bit.
- Masked lines still latch pending. The mask gates arbitration only.
- Arbitration: among `pending & ien`, the lowest index wins.
- FSM states:
  - IDLE: if any `pending & ien`, latch winner index `cur` and go to REQ.
  - REQ: `int_req`=1. On `int_clr`, clear `pending[cur]` and go to SVC.
  - SVC: `in_service`=1. On `eoi`, go to IDLE.
- `int_vector` = `VEC_BASE + 2*cur` in REQ and SVC; 0 in IDLE.
- `int_clr` outside REQ and `eoi` outside SVC are ignored.
- Once REQ is entered, `cur` is committed. Clearing its enable bit in REQ does not drop `int_req`.
- Rise on `pending[cur]` in the same cycle as `int_clr`: the set wins, so the bit stays pending.
- No nesting: new requests, including higher-priority ones, wait in pending until IDLE.
- `ien_wr` takes effect at the next edge in any state.

## Timing
- Reset values: `int_req`=0, `in_service`=0, `int_vector`=0, `pending`=0, `ien`=0, FSM=IDLE, synchroniser/prev flops=0.
- Assertion of `rst` mid-operation aborts immediately to these values. An open service window is discarded without `eoi`.
- Latency: `irq_in` high first sampled at edge k.
  - `sync2` high at k+1.
  - `pending` set at k+2.
  - REQ entered and `int_req`=1 at k+3, if the line is enabled and the FSM is IDLE at k+2.
- `int_clr` high at edge m in REQ: `int_req`=0 and `in_service`=1 after m.
- `eoi` at edge n in SVC: IDLE after n. The next pending request can raise `int_req` after n+1.
- Pulses on `irq_in` shorter than one clock may be missed. Sources hold at least 2 cycles.

## Structure
- Package `pdua_int_pkg` holds:
  - state enum `int_state_t` {IDLE, REQ, SVC}
  - default `VEC_BASE`
  - a `vector_of(idx)` function.
- Sub-module `irq_sync_edge` (one line: synchroniser, prev flop, rise pulse) is instantiated `N_IRQ` times.
- Top holds pending, mask, priority encoder and FSM.

## Test plan
- Reset: hold `rst`=0 with `irq_in`=4'hF -> all outputs 0. Release, no `ien_wr` -> `pending`=4'hF, `int_req` stays 0.
- Single request: `ien`=4'b0100, rise on line 2 at edge k -> `int_req`=1 at k+3, `int_vector`=8'hF4. `int_clr` -> `pending[2]`=0, `in_service`=1. `eoi` -> IDLE, `int_vector`=0.
- Priority: lines 3 and 1 rise in the same cycle, `ien`=4'hF -> vector 8'hF2 first. After `eoi` -> `int_req` again at the next cycle with 8'hF6.
- Same-cycle set/clear: rise on line 0 lands on the `int_clr` edge for line 0 -> `pending[0]` stays 1 and is re-requested after `eoi`.
- Mask change: in REQ for line 1, write `ien`=0 -> `int_req` held and ack proceeds normally. Then a pending line 2 -> no request until re-enabled.
- Reset mid-SVC: `rst` low while `in_service`=1 -> immediate return to reset values. A stray `eoi` after release is ignored.
